// File: rtl/fp_div_seq.sv
// Sequential floating-point divider: one restoring quotient bit per cycle,
// start/busy/done handshake, truncating, with zero/div-by-zero/over/underflow handling.
module fp_div_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int BIAS  = 127
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [EXP_W+MAN_W:0]   A,
    input  logic [EXP_W+MAN_W:0]   B,
    input  logic                   red_A,
    input  logic                   red_B,
    output logic                   busy,
    output logic                   done,
    output logic [EXP_W+MAN_W:0]   out,
    output logic                   overflow,
    output logic                   underflow,
    output logic                   div_by_zero
);
    localparam int W  = EXP_W + MAN_W + 1;
    localparam int RW = MAN_W + 3;
    localparam int QW = MAN_W + 2;
    localparam int EW = EXP_W + 2;
    localparam int CW = $clog2(MAN_W + 3);
    localparam logic signed [EW-1:0] MAX_EXP = EW'((1 << EXP_W) - 2);
    localparam logic signed [EW-1:0] MIN_EXP = EW'(1);

    typedef enum logic [2:0] {S_IDLE, S_DIVIDE, S_NORM, S_SPECIAL, S_DONE} state_t;

    state_t             state_q, state_d;
    logic               sa_q, sa_d, sb_q, sb_d;
    logic [EXP_W-1:0]   ea_q, ea_d, eb_q, eb_d;
    logic               a_zero_q, a_zero_d;
    logic [RW-1:0]      rem_q, rem_d, div_q, div_d;
    logic [QW-1:0]      quo_q, quo_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [W-1:0]       out_q, out_d;
    logic               ovf_q, ovf_d, unf_q, unf_d, dbz_q, dbz_d;

    logic               a_zero, b_zero;
    logic [RW:0]        trial;
    logic               q_bit;
    logic [RW-1:0]      rem_kept;
    logic               sign;
    logic signed [EW-1:0] e_raw, e_adj;
    logic [MAN_W-1:0]   man;

    assign a_zero = (A[W-2:0] == '0);
    assign b_zero = (B[W-2:0] == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            ea_q     <= '0;
            eb_q     <= '0;
            a_zero_q <= 1'b0;
            rem_q    <= '0;
            div_q    <= '0;
            quo_q    <= '0;
            cnt_q    <= '0;
            out_q    <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            ea_q     <= ea_d;
            eb_q     <= eb_d;
            a_zero_q <= a_zero_d;
            rem_q    <= rem_d;
            div_q    <= div_d;
            quo_q    <= quo_d;
            cnt_q    <= cnt_d;
            out_q    <= out_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            dbz_q    <= dbz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start) state_d = (a_zero || b_zero) ? S_SPECIAL : S_DIVIDE;
            S_DIVIDE:  if (cnt_q == CW'(1)) state_d = S_NORM;
            S_NORM:    state_d = S_DONE;
            S_SPECIAL: state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Restoring step: the extra top bit of trial is the borrow.
    assign trial    = {1'b0, rem_q} - {1'b0, div_q};
    assign q_bit    = ~trial[RW];
    assign rem_kept = q_bit ? trial[RW-1:0] : rem_q;

    assign sign  = sa_q ^ sb_q;
    assign e_raw = EW'({2'b00, ea_q}) - EW'({2'b00, eb_q}) + EW'(BIAS);

    always_comb begin
        if (quo_q[QW-1]) begin
            man   = quo_q[MAN_W:1];
            e_adj = e_raw;
        end else begin
            man   = quo_q[MAN_W-1:0];
            e_adj = e_raw - EW'(1);
        end
    end

    always_comb begin
        sa_d     = sa_q;
        sb_d     = sb_q;
        ea_d     = ea_q;
        eb_d     = eb_q;
        a_zero_d = a_zero_q;
        rem_d    = rem_q;
        div_d    = div_q;
        quo_d    = quo_q;
        cnt_d    = cnt_q;
        out_d    = out_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        dbz_d    = dbz_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sa_d     = A[W-1];
                    sb_d     = B[W-1];
                    ea_d     = A[W-2:MAN_W];
                    eb_d     = B[W-2:MAN_W];
                    a_zero_d = a_zero;
                    rem_d    = {1'b0, red_A, A[MAN_W-1:0]};
                    div_d    = {1'b0, red_B, B[MAN_W-1:0]};
                    quo_d    = '0;
                    cnt_d    = CW'(QW);
                    ovf_d    = 1'b0;
                    unf_d    = 1'b0;
                    dbz_d    = 1'b0;
                end
            end
            S_DIVIDE: begin
                rem_d = rem_kept << 1;
                quo_d = {quo_q[QW-2:0], q_bit};
                cnt_d = cnt_q - CW'(1);
            end
            S_NORM: begin
                if (e_adj > MAX_EXP) begin
                    out_d = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    ovf_d = 1'b1;
                end else if (e_adj < MIN_EXP) begin
                    out_d = {sign, {(W-1){1'b0}}};
                    unf_d = 1'b1;
                end else begin
                    out_d = {sign, e_adj[EXP_W-1:0], man};
                end
            end
            S_SPECIAL: begin
                if (a_zero_q) begin
                    out_d = {sign, {(W-1){1'b0}}};
                end else begin
                    out_d = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    dbz_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        busy        = (state_q != S_IDLE);
        done        = (state_q == S_DONE);
        out         = out_q;
        overflow    = ovf_q;
        underflow   = unf_q;
        div_by_zero = dbz_q;
    end
endmodule

// File: tb/tb_fp_div_seq.sv
// Scoreboard bench for fp_div_seq: expected results are queued at issue and
// compared (value, flags, latency) when done rises.
module tb_fp_div_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] A = '0, B = '0;
    logic        red_A = 1'b0, red_B = 1'b0;
    logic        busy, done, overflow, underflow, div_by_zero;
    logic [31:0] dout;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] out;
        logic        ov;
        logic        un;
        logic        dz;
        int          lat;
        string       name;
    } exp_t;
    exp_t sb[$];

    fp_div_seq #(.EXP_W(8), .MAN_W(23), .BIAS(127)) dut (
        .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
        .red_A(red_A), .red_B(red_B), .busy(busy), .done(done),
        .out(dout), .overflow(overflow), .underflow(underflow),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    // inject: pulse a conflicting start so it is sampled at edges 5 and 26.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         input logic ra, input logic rb,
                         input logic [31:0] eo, input logic eov, input logic eun,
                         input logic edz, input int elat, input string name,
                         input logic inject);
        exp_t e;
        exp_t got;
        int   n;
        e.out = eo; e.ov = eov; e.un = eun; e.dz = edz; e.lat = elat; e.name = name;
        sb.push_back(e);
        @(negedge clk);
        A = a; B = b; red_A = ra; red_B = rb; start = 1'b1;
        @(posedge clk);
        n = 1;
        #1;
        start = 1'b0;
        A = 32'h3F80_0000; B = 32'h4040_0000;
        while (done !== 1'b1 && n < 80) begin
            if (inject && (n == 4 || n == 25)) begin
                A = 32'h3F80_0000; B = 32'h0000_0000; red_B = 1'b0; start = 1'b1;
            end
            @(posedge clk);
            n++;
            #1;
            start = 1'b0;
        end
        got = sb.pop_front();
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s timeout: done never rose within %0d edges", got.name, n);
        end
        checks++;
        if (dout !== got.out) begin
            errors++;
            $display("FAIL %s out: got %08h expected %08h", got.name, dout, got.out);
        end
        checks++;
        if ({overflow, underflow, div_by_zero} !== {got.ov, got.un, got.dz}) begin
            errors++;
            $display("FAIL %s flags(ov,un,dz): got %b%b%b expected %b%b%b", got.name,
                     overflow, underflow, div_by_zero, got.ov, got.un, got.dz);
        end
        checks++;
        if (n != got.lat || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s latency/busy: got %0d busy=%b expected %0d busy=1",
                     got.name, n, busy, got.lat);
        end
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s idle after done: busy=%b done=%b expected 0 0", got.name, busy, done);
        end
        $display("op %-14s A=%08h B=%08h out=%08h ov=%b un=%b dz=%b lat=%0d",
                 got.name, a, b, dout, overflow, underflow, div_by_zero, n);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, dout, overflow, underflow, div_by_zero} !== 37'd0) begin
            errors++;
            $display("FAIL reset outputs: busy=%b done=%b out=%08h flags=%b%b%b expected all 0",
                     busy, done, dout, overflow, underflow, div_by_zero);
        end
        @(negedge clk);
        rst = 1'b0;
        $display("reset released");
    endtask

    task automatic test_normal();
        do_op(32'h40C0_0000, 32'h4000_0000, 1, 1, 32'h4040_0000, 0, 0, 0, 27, "6/2", 0);
        do_op(32'h3F80_0000, 32'h4040_0000, 1, 1, 32'h3EAA_AAAA, 0, 0, 0, 27, "1/3", 0);
        do_op(32'hC0C0_0000, 32'h4000_0000, 1, 1, 32'hC040_0000, 0, 0, 0, 27, "-6/2", 0);
    endtask

    task automatic test_special();
        do_op(32'h3F80_0000, 32'h0000_0000, 1, 0, 32'h7F80_0000, 0, 0, 1, 2, "1/0", 0);
        do_op(32'h0000_0000, 32'h40A0_0000, 0, 1, 32'h0000_0000, 0, 0, 0, 2, "0/5", 0);
        do_op(32'h0000_0000, 32'h8000_0000, 0, 0, 32'h8000_0000, 0, 0, 0, 2, "0/-0", 0);
    endtask

    task automatic test_saturate();
        do_op(32'h7F00_0000, 32'h0080_0000, 1, 1, 32'h7F80_0000, 1, 0, 0, 27, "overflow", 0);
        do_op(32'h0080_0000, 32'h7F00_0000, 1, 1, 32'h0000_0000, 0, 1, 0, 27, "underflow", 0);
    endtask

    task automatic test_ignored_start();
        do_op(32'h40C0_0000, 32'h4000_0000, 1, 1, 32'h4040_0000, 0, 0, 0, 27, "6/2 inject", 1);
    endtask

    task automatic test_back_to_back();
        do_op(32'h3F80_0000, 32'h4040_0000, 1, 1, 32'h3EAA_AAAA, 0, 0, 0, 27, "b2b first", 0);
        do_op(32'hC0C0_0000, 32'h4000_0000, 1, 1, 32'hC040_0000, 0, 0, 0, 27, "b2b second", 0);
    endtask

    task automatic test_async_reset();
        int n;
        @(negedge clk);
        A = 32'h3F80_0000; B = 32'h4040_0000; red_A = 1; red_B = 1; start = 1'b1;
        @(posedge clk);
        n = 1;
        #1;
        start = 1'b0;
        while (n < 10) begin
            @(posedge clk);
            n++;
        end
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, dout, overflow, underflow, div_by_zero} !== 37'd0) begin
            errors++;
            $display("FAIL async reset: busy=%b done=%b out=%08h flags=%b%b%b expected all 0",
                     busy, done, dout, overflow, underflow, div_by_zero);
        end
        $display("async reset asserted at cycle %0d busy=%b out=%08h", n, busy, dout);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL post-reset idle: busy=%b expected 0", busy);
        end
        do_op(32'h40C0_0000, 32'h4000_0000, 1, 1, 32'h4040_0000, 0, 0, 0, 27, "after reset", 0);
    endtask

    initial begin
        test_reset();
        test_normal();
        test_special();
        test_saturate();
        test_ignored_start();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
